// File: rtl/pid_multi_core_if.sv
// pid_multi_core_if: sample/gain/config inputs and control outputs of
// pid_multi_core. The master modport drives samples and gains, the slave
// modport is the core.
interface pid_multi_core_if #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int IW  = 40,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
);
  logic                  enable_i;
  logic                  strobe_i;
  logic                  ready_o;
  logic [CHW-1:0]        ch_i;
  logic signed [DW-1:0]  dat_i;
  logic signed [DW-1:0]  sp_i;
  logic signed [CW-1:0]  kp_i;
  logic signed [CW-1:0]  ki_i;
  logic signed [CW-1:0]  kd_i;
  logic [3:0]            alpha_i;
  logic [13:0]           decimate_i;
  logic [IW-2:0]         int_lim_i;
  logic signed [DW-1:0]  dat_o;
  logic [CHW-1:0]        ch_o;
  logic                  valid_o;
  logic                  sat_o;

  modport master (
    output enable_i, strobe_i, ch_i, dat_i, sp_i, kp_i, ki_i, kd_i,
           alpha_i, decimate_i, int_lim_i,
    input  ready_o, dat_o, ch_o, valid_o, sat_o
  );

  modport slave (
    input  enable_i, strobe_i, ch_i, dat_i, sp_i, kp_i, ki_i, kd_i,
           alpha_i, decimate_i, int_lim_i,
    output ready_o, dat_o, ch_o, valid_o, sat_o
  );
endinterface

// File: rtl/pid_multi_core.sv
// pid_multi_core: time-multiplexed PID controller for NCH loops sharing one
// multiply/accumulate datapath. Per-channel integrator, derivative filter and
// decimation counter. Sequence per processed sample: IDLE→ERR→PROD→ACC→OUT.
// Optional feature: define PID_COND_INT_EN for conditional integration
// (integrator frozen while the output saturates in the direction of Ti).
module pid_multi_core #(
  parameter int NCH  = 4,
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 13,
  parameter int IW   = 40
) (
  input  logic           clk,
  input  logic           rst_n,
  pid_multi_core_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW  = DW + 1;    // error / filtered error
  localparam int DDW = DW + 2;    // derivative term
  localparam int PW  = CW + EW;   // kp*e, ki*e
  localparam int DPW = CW + DDW;  // kd*d
  localparam int SW  = IW + 2;    // output sum

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_PROD, S_ACC, S_OUT} state_t;
  state_t state_q, state_d;

  // values latched at accept
  logic [CHW-1:0]        ch_q, ch_d;
  logic signed [DW-1:0]  dat_q, dat_d, sp_q, sp_d;
  logic signed [CW-1:0]  kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic [3:0]            alpha_q, alpha_d;

  // pipeline registers between stages
  logic signed [EW-1:0]  e_q, e_d, efn_q, efn_d;
  logic signed [DDW-1:0] d_q, d_d;
  logic signed [PW-1:0]  p_q, p_d, ti_q, ti_d;
  logic signed [DPW-1:0] dd_q, dd_d;
  logic signed [IW-1:0]  inew_q, inew_d;

  // output registers
  logic signed [DW-1:0]  dat_o_q, dat_o_d;
  logic [CHW-1:0]        ch_o_q, ch_o_d;
  logic                  valid_q, valid_d, sat_q, sat_d;

  // per-channel state
  logic signed [IW-1:0]  integ_q [NCH];
  logic signed [IW-1:0]  integ_d [NCH];
  logic signed [EW-1:0]  ef_q    [NCH];
  logic signed [EW-1:0]  ef_d    [NCH];
  logic [13:0]           dc_q    [NCH];
  logic [13:0]           dc_d    [NCH];

  // datapath combinational values
  logic                  accept;
  int unsigned           ch_ext;
  logic signed [EW-1:0]  ef_cur, err_c, efn_c;
  logic signed [DDW-1:0] diff_c, d_c;
  logic signed [IW-1:0]  i_cur, inew_c;
  logic signed [IW:0]    isum_c, ibase_c, iclamp_c, lim_pos, lim_neg;
  logic signed [SW-1:0]  s_c, ys_c;
  logic                  ovf_c;
  logic signed [DW-1:0]  y_c;
`ifdef PID_COND_INT_EN
  localparam int SUW = IW + 3;
  logic signed [SUW-1:0] s_unc, ys_unc;
`endif

  assign bus.ready_o = (state_q == S_IDLE);
  assign bus.dat_o   = dat_o_q;
  assign bus.ch_o    = ch_o_q;
  assign bus.valid_o = valid_q;
  assign bus.sat_o   = sat_q;

  // Arithmetic for ERR (filter/derivative) and ACC (integrator clamp, sum, saturation)
  always_comb begin
    ef_cur = ef_q[ch_q];
    i_cur  = integ_q[ch_q];
    err_c  = EW'(sp_q) - EW'(dat_q);
    diff_c = DDW'(err_c) - DDW'(ef_cur);
    // the filtered value lies between ef and e, so EW-bit wraparound is exact
    efn_c  = ef_cur + EW'(diff_c >>> alpha_q);
    d_c    = DDW'(efn_c) - DDW'(ef_cur);

    isum_c  = (IW+1)'(i_cur) + (IW+1)'(ti_q);
    lim_pos = {2'b00, bus.int_lim_i};
    lim_neg = -lim_pos;
    ibase_c = isum_c;
`ifdef PID_COND_INT_EN
    s_unc  = SUW'(p_q) + SUW'(isum_c) + SUW'(dd_q);
    ys_unc = s_unc >>> FRAC;
    if (ys_unc[SUW-1:DW-1] != {(SUW-DW+1){ys_unc[SUW-1]}}) begin
      if ((!ys_unc[SUW-1] && !ti_q[PW-1] && (ti_q != '0)) ||
          (ys_unc[SUW-1] && ti_q[PW-1])) begin
        ibase_c = (IW+1)'(i_cur);
      end
    end
`endif
    if (ibase_c > lim_pos) begin
      iclamp_c = lim_pos;
    end else if (ibase_c < lim_neg) begin
      iclamp_c = lim_neg;
    end else begin
      iclamp_c = ibase_c;
    end
    inew_c = IW'(iclamp_c);

    s_c   = SW'(p_q) + SW'(inew_c) + SW'(dd_q);
    ys_c  = s_c >>> FRAC;
    ovf_c = (ys_c[SW-1:DW-1] != {(SW-DW+1){ys_c[SW-1]}});
    if (!ovf_c) begin
      y_c = ys_c[DW-1:0];
    end else if (ys_c[SW-1]) begin
      y_c = {1'b1, {(DW-1){1'b0}}};
    end else begin
      y_c = {1'b0, {(DW-1){1'b1}}};
    end
  end

  // FSM next-state, accept/decimation and stage register updates
  always_comb begin
    state_d = state_q;
    ch_d = ch_q; dat_d = dat_q; sp_d = sp_q;
    kp_d = kp_q; ki_d = ki_q; kd_d = kd_q; alpha_d = alpha_q;
    e_d = e_q; efn_d = efn_q; d_d = d_q;
    p_d = p_q; ti_d = ti_q; dd_d = dd_q; inew_d = inew_q;
    dat_o_d = dat_o_q; ch_o_d = ch_o_q; sat_d = sat_q;
    valid_d = 1'b0;
    integ_d = integ_q;
    ef_d    = ef_q;
    dc_d    = dc_q;
    ch_ext  = 32'(bus.ch_i);
    accept  = bus.strobe_i && (state_q == S_IDLE) && bus.enable_i && (ch_ext < NCH);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ch_d = bus.ch_i; dat_d = bus.dat_i; sp_d = bus.sp_i;
          kp_d = bus.kp_i; ki_d = bus.ki_i; kd_d = bus.kd_i;
          alpha_d = bus.alpha_i;
          if (dc_q[bus.ch_i] != '0) begin
            dc_d[bus.ch_i] = dc_q[bus.ch_i] - 14'd1;
          end else begin
            dc_d[bus.ch_i] = bus.decimate_i;
            state_d = S_ERR;
          end
        end
      end
      S_ERR: begin
        e_d = err_c; efn_d = efn_c; d_d = d_c;
        state_d = S_PROD;
      end
      S_PROD: begin
        p_d  = PW'(kp_q) * PW'(e_q);
        ti_d = PW'(ki_q) * PW'(e_q);
        dd_d = DPW'(kd_q) * DPW'(d_q);
        state_d = S_ACC;
      end
      S_ACC: begin
        // output registered here so valid_o is visible during OUT
        inew_d  = inew_c;
        dat_o_d = y_c;
        sat_d   = ovf_c;
        ch_o_d  = ch_q;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        integ_d[ch_q] = inew_q;
        ef_d[ch_q]    = efn_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!bus.enable_i) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      dat_o_d = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        integ_d[i] = '0;
        ef_d[i]    = '0;
        dc_d[i]    = '0;
      end
    end
  end

  // FSM, latched sample, pipeline and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q <= '0; dat_q <= '0; sp_q <= '0;
      kp_q <= '0; ki_q <= '0; kd_q <= '0; alpha_q <= '0;
      e_q <= '0; efn_q <= '0; d_q <= '0;
      p_q <= '0; ti_q <= '0; dd_q <= '0; inew_q <= '0;
      dat_o_q <= '0; ch_o_q <= '0; valid_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d; dat_q <= dat_d; sp_q <= sp_d;
      kp_q <= kp_d; ki_q <= ki_d; kd_q <= kd_d; alpha_q <= alpha_d;
      e_q <= e_d; efn_q <= efn_d; d_q <= d_d;
      p_q <= p_d; ti_q <= ti_d; dd_q <= dd_d; inew_q <= inew_d;
      dat_o_q <= dat_o_d; ch_o_q <= ch_o_d; valid_q <= valid_d; sat_q <= sat_d;
    end
  end

  // Per-channel integrator, filter and decimation state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        integ_q[i] <= '0;
        ef_q[i]    <= '0;
        dc_q[i]    <= '0;
      end
    end else begin
      integ_q <= integ_d;
      ef_q    <= ef_d;
      dc_q    <= dc_d;
    end
  end
endmodule

// File: tb/tb_pid_multi_core.sv
// tb_pid_multi_core: directed vectors for pid_multi_core. Stimulus pushes the
// hand-computed response into a scoreboard queue; a monitor pops and compares
// on every valid_o pulse.
module tb_pid_multi_core;
  localparam int NCH = 4, DW = 16, CW = 16, FRAC = 13, IW = 40, CHW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pid_multi_core_if #(.NCH(NCH), .DW(DW), .CW(CW), .IW(IW)) bus ();

  pid_multi_core #(.NCH(NCH), .DW(DW), .CW(CW), .FRAC(FRAC), .IW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int dat;
    int ch;
    bit sat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every valid_o pulse must match the oldest expected response
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got dat_o=%0d ch_o=%0d, expected no output",
                   $signed(bus.dat_o), bus.ch_o);
        end else begin
          x = sb.pop_front();
          chk("dat_o",   longint'($signed(bus.dat_o)), x.dat);
          chk("ch_o",    bus.ch_o, x.ch);
          chk("sat_o",   bus.sat_o, x.sat);
          chk("latency", edges, x.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus.ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready_o=%b expected 1 within 50 cycles", bus.ready_o);
    end
  endtask

  task automatic set_gains(input int kp, input int ki, input int kd, input int alpha);
    bus.kp_i = CW'(kp);
    bus.ki_i = CW'(ki);
    bus.kd_i = CW'(kd);
    bus.alpha_i = 4'(alpha);
  endtask

  task automatic clear_state();
    @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
    bus.enable_i = 1'b1;
  endtask

  // Accept edge counted as edge A; busy cycles are the four that follow it,
  // valid_o appears in the last of them (counter A+3), ready_o returns after.
  task automatic send(input int ch, input int dat, input int sp, input bit compute,
                      input int exp_dat, input bit exp_sat, input bit poke);
    exp_t x;
    wait_ready();
    bus.ch_i  = CHW'(ch);
    bus.dat_i = DW'(dat);
    bus.sp_i  = DW'(sp);
    bus.strobe_i = 1'b1;
    @(posedge clk);
    #1;
    bus.strobe_i = 1'b0;
    if (compute) begin
      x.dat = exp_dat; x.ch = ch; x.sat = exp_sat; x.cyc = edges + 3;
      sb.push_back(x);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("ready_busy", bus.ready_o, 0);
        if (poke && k == 0) begin
          bus.ch_i = 2'd2; bus.sp_i = 16'sd1000; bus.dat_i = '0; bus.strobe_i = 1'b1;
        end
        if (poke && k == 2) bus.strobe_i = 1'b0;
      end
      @(negedge clk);
      chk("ready_back", bus.ready_o, 1);
    end else begin
      @(negedge clk);
      chk("ready_drop", bus.ready_o, 1);
    end
  endtask

  // Accept a ch0 sample, then kill it two cycles later by enable or reset
  task automatic abort_mid(input bit use_rst);
    wait_ready();
    bus.ch_i = '0; bus.dat_i = '0; bus.sp_i = 16'sd10; bus.strobe_i = 1'b1;
    @(posedge clk);
    #1;
    bus.strobe_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (use_rst) rst_n = 1'b0; else bus.enable_i = 1'b0;
    @(negedge clk);
    chk("abort_ready", bus.ready_o, 1);
    chk("abort_valid", bus.valid_o, 0);
    chk("abort_dat_o", longint'($signed(bus.dat_o)), 0);
    rst_n = 1'b1;
    bus.enable_i = 1'b1;
  endtask

  initial begin : stim
    rst_n = 1'b0;
    bus.enable_i = 1'b1; bus.strobe_i = 1'b0;
    bus.ch_i = '0; bus.dat_i = '0; bus.sp_i = '0;
    set_gains(0, 0, 0, 0);
    bus.decimate_i = '0;
    bus.int_lim_i  = 39'(1) << 38;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_dat_o", longint'($signed(bus.dat_o)), 0);
    chk("rst_ch_o",  bus.ch_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_sat",   bus.sat_o, 0);
    rst_n = 1'b1;

    // proportional: 8192*10 >>> 13 = 10
    set_gains(8192, 0, 0, 0);
    send(0, 0, 10, 1, 10, 0, 0);

    // integrator with clamp at 163840 (=20 after shift)
    clear_state();
    set_gains(0, 8192, 0, 0);
    bus.int_lim_i = 39'd163840;
    send(0, 0, 10, 1, 10, 0, 0);
    send(0, 0, 10, 1, 20, 0, 0);
    send(0, 0, 10, 1, 20, 0, 0);
    send(0, 0, 10, 1, 20, 0, 0);
    clear_state();
    bus.int_lim_i = 39'(1) << 38;
    send(0, 0, 10, 1, 10, 0, 0);
    send(0, 0, 10, 1, 20, 0, 0);
    send(0, 0, 10, 1, 30, 0, 0);
    send(0, 0, 10, 1, 40, 0, 0);

    // output saturation both directions
    clear_state();
    set_gains(16383, 0, 0, 0);
    send(0, -30000, 30000, 1, 32767, 1, 0);
    send(0, 30000, -30000, 1, -32768, 1, 0);

    // derivative, unfiltered then alpha=1
    clear_state();
    set_gains(0, 0, 8192, 0);
    send(0, 0, 0,   1, 0,   0, 0);
    send(0, 0, 100, 1, 100, 0, 0);
    send(0, 0, 100, 1, 0,   0, 0);
    clear_state();
    set_gains(0, 0, 8192, 1);
    send(0, 0, 0,   1, 0,  0, 0);
    send(0, 0, 100, 1, 50, 0, 0);
    send(0, 0, 100, 1, 25, 0, 0);

    // decimation by 3: only the 1st and 4th samples produce output
    clear_state();
    set_gains(8192, 0, 0, 0);
    bus.decimate_i = 14'd2;
    for (int i = 1; i <= 6; i++) send(0, 0, i, (i == 1 || i == 4), i, 0, 0);
    bus.decimate_i = '0;

    // channel isolation; a strobe while busy (ch2, e=1000) must be ignored
    set_gains(0, 8192, 0, 0);
    send(0, 0, 10, 1, 10, 0, 0);
    send(1, 0, 20, 1, 20, 0, 1);
    send(0, 0, 10, 1, 20, 0, 0);
    send(1, 0, 20, 1, 40, 0, 0);
    send(2, 0, 5,  1, 5,  0, 0);

    // strobe with enable low is dropped
    @(negedge clk);
    bus.enable_i = 1'b0; bus.ch_i = 2'd3; bus.sp_i = 16'sd1000; bus.strobe_i = 1'b1;
    @(negedge clk);
    bus.strobe_i = 1'b0; bus.enable_i = 1'b1;
    send(3, 0, 5, 1, 5, 0, 0);

    // mid-computation abort by enable, then by reset
    clear_state();
    send(0, 0, 10, 1, 10, 0, 0);
    abort_mid(0);
    send(0, 0, 10, 1, 10, 0, 0);
    send(0, 0, 10, 1, 20, 0, 0);
    abort_mid(1);
    send(0, 0, 10, 1, 10, 0, 0);

    // integration during saturation
    clear_state();
    set_gains(0, 8192, 0, 0);
    send(0, 0, 10, 1, 10, 0, 0);
    set_gains(16383, 8192, 0, 0);
    send(0, -30000, 30000, 1, 32767, 1, 0);
    set_gains(0, 8192, 0, 0);
`ifdef PID_COND_INT_EN
    send(0, 0, 0, 1, 10, 0, 0);
`else
    send(0, 0, 0, 1, 32767, 1, 0);
`endif

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pid_multi_core.md
# pid_multi_core

Parametrised, time-multiplexed PID controller. It serves up to NCH independent loops from one shared multiply/accumulate datapath, with per-channel integrator, derivative-filter and decimation state. Compared with the single-channel PID core it adds:
- configurable data and coefficient widths;
- integrator clamping (anti-windup);
- output saturation with a saturation flag;
- a ready/valid handshake.

It sits between the ADC-side demodulation/filter stage and the DAC/actuator mux in the lock-loop path.

## Interface
Parameters:
- NCH, 4, number of channels (≥1)
- DW, 16, signed data/setpoint/output width
- CW, 16, signed coefficient width
- FRAC, 13, fractional bits of kp/ki/kd (8192 = 1.0 at default)
- IW, 40, signed integrator width (≥ DW+CW+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable_i  in  1  run enable; low clears all loop state
- strobe_i  in  1  sample valid
- ready_o  out  1  core can accept a strobe
- ch_i  in  $clog2(NCH) (min 1)  channel of the incoming sample
- dat_i  in  DW  signed process value
- sp_i  in  DW  signed setpoint
- kp_i, ki_i, kd_i  in  CW each  signed gains, shared by all channels
- alpha_i  in  4  derivative low-pass shift (0 = unfiltered)
- decimate_i  in  14  process 1 of every decimate_i+1 samples per channel
- int_lim_i  in  IW-1  unsigned integrator magnitude limit
- dat_o  out  DW  signed saturated control output
- ch_o  out  $clog2(NCH)  channel of dat_o
- valid_o  out  1  one-cycle pulse, dat_o/ch_o/sat_o valid
- sat_o  out  1  output was saturated

## Operation
- **Accept condition:** strobe_i & ready_o & enable_i & (ch_i < NCH). On accept, latch ch, dat, sp, kp, ki, kd and alpha.
- **Not accepted:** strobes while busy, with enable_i low, or with ch_i ≥ NCH are dropped. They are never queued.
- **Decimation:** each channel has a counter dc[ch].
  - On accept, if dc[ch] ≠ 0: decrement it and drop the sample (no output, ready_o stays 1).
  - Otherwise: reload dc[ch] = decimate_i and compute.
  - decimate_i = 0 processes every sample.
- **FSM states:** IDLE → ERR → PROD → ACC → OUT → IDLE. ready_o = 1 only in IDLE.
  - **ERR:**
    - e = sp − dat, DW+1 bits.
    - ef_new = ef[ch] + ((e − ef[ch]) >>> alpha), arithmetic shift, DW+1 bits.
    - d = ef_new − ef[ch].
  - **PROD:** P = kp·e, Ti = ki·e, D = kd·d. All full-precision signed.
  - **ACC:**
    - I_new = clamp(I[ch] + Ti, −int_lim_i, +int_lim_i).
    - S = P + I_new + D, in IW+2 bits.
  - **OUT:**
    - y = S >>> FRAC, saturated to [−2^(DW−1), 2^(DW−1)−1].
    - sat_o = 1 if clipped.
    - Write I[ch] and ef[ch].
    - Register dat_o and ch_o, pulse valid_o.
- **enable_i low:** FSM forced to IDLE; I, ef and dc for all channels zeroed; dat_o = 0; valid_o = 0. An in-flight computation is discarded without writeback.
- **Outputs:** dat_o, ch_o and sat_o hold their value between valid_o pulses.

## Timing
- **Reset values:** ready_o = 1, dat_o = 0, ch_o = 0, valid_o = 0, sat_o = 0. FSM = IDLE. All per-channel state = 0.
- **Latency:** accept on edge N → valid_o high in cycle N+4. ready_o is low for cycles N+1..N+4, and high again at N+5.
- **Throughput:** back-to-back accepts are possible every 5 cycles.
- **Reset mid-operation:** immediate return to the reset values, no writeback.
- **Ordering:** a decimated (dropped) strobe costs 1 cycle and leaves ready_o high.
- **Gain changes:** kp/ki/kd/alpha may change at any time. Only the values latched at accept are used.

## Configuration
- **PID_COND_INT_EN defined:** conditional integration. In ACC, if the unclamped S would saturate y and Ti has the same sign as the saturation direction, set I_new = I[ch] (integrator frozen). The clamp still applies.
- **Undefined:** the integrator always updates, limited only by int_lim_i.

## Test plan
- **Proportional:** kp = 8192, ki = kd = 0, sp = 10, dat = 0, ch 0 → dat_o = 10, ch_o = 0, valid_o exactly 4 cycles after accept, sat_o = 0.
- **Integrator and clamp:** ki = 8192, kp = kd = 0, e = 10, int_lim_i = 163840, four processed samples → dat_o = 10, 20, 20, 20. With int_lim_i = 2^38: 10, 20, 30, 40.
- **Saturation:** kp = 16383, sp = 30000, dat = −30000 → dat_o = 32767, sat_o = 1. Negated inputs → −32768, sat_o = 1.
- **Derivative:** kd = 8192, alpha = 0, e steps 0 → 100 → 100 → outputs 0, 100, 0. With alpha = 1 → 0, 50, 25.
- **Decimation and channel isolation:**
  - decimate_i = 2, six accepted ch0 strobes → valid_o only on the 1st and 4th.
  - Interleave ch1 integrating samples → ch1 starts from 0, unaffected by ch0.
  - Strobe while ready_o = 0 → ignored.
- **Enable/reset mid-op:** drop enable_i or assert rst_n low at cycle N+2 → no valid_o, integrator reads 0 on the next computation. With PID_COND_INT_EN, saturated integration → integrator holds its pre-saturation value.
